// File: rtl/amo_seq_ctrl.sv
// rtl/amo_seq_ctrl.sv - atomic memory operation sequencer with LR/SC reservation
//
// Runs AMO*/LR/SC from the MEM stage as a read-modify-write on the data bus
// while holding the MEM/WB register, then strobes the result for one cycle.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   is_amo_instr_mem ..    MEM-stage atomic instruction, operands, cancel/flush
//   snoop_st_*             committed non-atomic stores (reservation kill)
//   bus_*                  single-outstanding data bus, held stable until bus_ack
//   hold                   pipeline freeze (start cycle, RD, WR)
//   amo_val_lockup         one-cycle strobe qualifying amo_result/is_fail_sc_mem
//   resv_valid             reservation held

module amo_seq_ctrl #(
  parameter int XLEN      = 64,
  parameter int RESV_GRAN = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            is_amo_instr_mem,
  input  logic [4:0]      amo_funct5_mem,
  input  logic            amo_word_mem,
  input  logic            cancel_instr_mem,
  input  logic            flush_mem,
  input  logic [XLEN-1:0] amo_addr_mem,
  input  logic [XLEN-1:0] amo_src_mem,
  input  logic            snoop_st_valid,
  input  logic [XLEN-1:0] snoop_st_addr,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic            hold,
  output logic            amo_val_lockup,
  output logic [XLEN-1:0] amo_result,
  output logic            is_fail_sc_mem,
  output logic            resv_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_LR, OP_SC, OP_SWAP, OP_ADD, OP_XOR, OP_AND, OP_OR,
    OP_MIN, OP_MAX, OP_MINU, OP_MAXU
  } op_e;

  // Only address bits at or above the granule size take part in a match.
  localparam logic [XLEN-1:0] GRAN_MASK = {XLEN{1'b1}} << RESV_GRAN;

  state_e          state_q;
  op_e             op_q;
  logic            word_q;
  logic [XLEN-1:0] src_q;
  logic [XLEN-1:0] old_q;
  logic            resv_valid_q;
  logic [XLEN-1:0] resv_addr_q;
  logic            bus_req_q;
  logic            bus_we_q;
  logic [XLEN-1:0] bus_addr_q;
  logic [XLEN-1:0] bus_wdata_q;
  logic            lockup_q;
  logic [XLEN-1:0] result_q;
  logic            fail_q;

  op_e             op_dec;
  logic            start;
  logic            snoop_kill;
  logic            sc_ok;
  logic [XLEN-1:0] rd_ext;
  logic [XLEN-1:0] src_ext;
  logic [XLEN-1:0] alu_out;
  logic            lt_s;
  logic            lt_u;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic gran_match(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return ((a ^ b) & GRAN_MASK) == '0;
  endfunction

  always_comb begin
    op_dec = OP_SWAP;
    case (amo_funct5_mem)
      5'b00010: op_dec = OP_LR;
      5'b00011: op_dec = OP_SC;
      5'b00001: op_dec = OP_SWAP;
      5'b00000: op_dec = OP_ADD;
      5'b00100: op_dec = OP_XOR;
      5'b01100: op_dec = OP_AND;
      5'b01000: op_dec = OP_OR;
      5'b10000: op_dec = OP_MIN;
      5'b10100: op_dec = OP_MAX;
      5'b11000: op_dec = OP_MINU;
      5'b11100: op_dec = OP_MAXU;
      default:  op_dec = OP_SWAP;
    endcase
  end

  assign start = (state_q == S_IDLE) && is_amo_instr_mem && !cancel_instr_mem && !flush_mem;

  // A store snooped in the same cycle as an SC start must already count as a kill.
  assign snoop_kill = snoop_st_valid && resv_valid_q && gran_match(snoop_st_addr, resv_addr_q);
  assign sc_ok      = resv_valid_q && !snoop_kill && gran_match(amo_addr_mem, resv_addr_q);

  // Both operands of a .W op are sign-extended to XLEN. That gives correct
  // signed and unsigned 32-bit ordering and a correct low-half sum.
  assign rd_ext  = word_q ? sext32(bus_rdata[31:0]) : bus_rdata;
  assign src_ext = word_q ? sext32(src_q[31:0]) : src_q;
  assign lt_s    = $signed(rd_ext) < $signed(src_ext);
  assign lt_u    = rd_ext < src_ext;

  always_comb begin
    alu_out = src_ext;
    case (op_q)
      OP_ADD:  alu_out = rd_ext + src_ext;
      OP_XOR:  alu_out = rd_ext ^ src_ext;
      OP_AND:  alu_out = rd_ext & src_ext;
      OP_OR:   alu_out = rd_ext | src_ext;
      OP_MIN:  alu_out = lt_s ? rd_ext : src_ext;
      OP_MAX:  alu_out = lt_s ? src_ext : rd_ext;
      OP_MINU: alu_out = lt_u ? rd_ext : src_ext;
      OP_MAXU: alu_out = lt_u ? src_ext : rd_ext;
      default: alu_out = src_ext;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      op_q         <= OP_SWAP;
      word_q       <= 1'b0;
      src_q        <= '0;
      old_q        <= '0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      lockup_q     <= 1'b0;
      result_q     <= '0;
      fail_q       <= 1'b0;
    end else begin
      lockup_q <= 1'b0;
      // The assignments below come later, so an LR set in this cycle wins over a snoop kill.
      if (snoop_kill) resv_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q       <= op_dec;
            word_q     <= amo_word_mem;
            src_q      <= amo_src_mem;
            bus_addr_q <= amo_addr_mem;
            if (op_dec == OP_SC) begin
              if (sc_ok) begin
                state_q     <= S_WR;
                bus_req_q   <= 1'b1;
                bus_we_q    <= 1'b1;
                bus_wdata_q <= amo_src_mem;
              end else begin
                state_q      <= S_DONE;
                lockup_q     <= 1'b1;
                fail_q       <= 1'b1;
                result_q     <= {{(XLEN-1){1'b0}}, 1'b1};
                resv_valid_q <= 1'b0;
              end
            end else begin
              state_q   <= S_RD;
              bus_req_q <= 1'b1;
              bus_we_q  <= 1'b0;
            end
          end
        end
        S_RD: begin
          if (bus_ack) begin
            old_q <= rd_ext;
            if (op_q == OP_LR) begin
              state_q      <= S_DONE;
              bus_req_q    <= 1'b0;
              resv_valid_q <= 1'b1;
              resv_addr_q  <= bus_addr_q;
              result_q     <= rd_ext;
              fail_q       <= 1'b0;
              lockup_q     <= 1'b1;
            end else begin
              state_q     <= S_WR;
              bus_we_q    <= 1'b1;
              bus_wdata_q <= alu_out;
            end
          end
        end
        S_WR: begin
          if (bus_ack) begin
            state_q   <= S_DONE;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            lockup_q  <= 1'b1;
            fail_q    <= 1'b0;
            if (op_q == OP_SC) begin
              resv_valid_q <= 1'b0;
              result_q     <= '0;
            end else begin
              result_q <= old_q;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign hold           = start || (state_q == S_RD) || (state_q == S_WR);
  assign bus_req        = bus_req_q;
  assign bus_we         = bus_we_q;
  assign bus_addr       = bus_addr_q;
  assign bus_wdata      = bus_wdata_q;
  assign amo_val_lockup = lockup_q;
  assign amo_result     = result_q;
  assign is_fail_sc_mem = fail_q;
  assign resv_valid     = resv_valid_q;

endmodule

// File: tb/tb_amo_seq_ctrl.sv
// tb/tb_amo_seq_ctrl.sv - scoreboard bench for amo_seq_ctrl

module tb_amo_seq_ctrl;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MINU = 5'b11000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        is_amo_instr_mem;
  logic [4:0]  amo_funct5_mem;
  logic        amo_word_mem;
  logic        cancel_instr_mem;
  logic        flush_mem;
  logic [63:0] amo_addr_mem;
  logic [63:0] amo_src_mem;
  logic        snoop_st_valid;
  logic [63:0] snoop_st_addr;
  logic        bus_ack;
  logic [63:0] bus_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic        hold;
  logic        amo_val_lockup;
  logic [63:0] amo_result;
  logic        is_fail_sc_mem;
  logic        resv_valid;

  amo_seq_ctrl #(.XLEN(64), .RESV_GRAN(3)) dut (
    .clk(clk), .rstn(rstn),
    .is_amo_instr_mem(is_amo_instr_mem), .amo_funct5_mem(amo_funct5_mem),
    .amo_word_mem(amo_word_mem), .cancel_instr_mem(cancel_instr_mem),
    .flush_mem(flush_mem), .amo_addr_mem(amo_addr_mem), .amo_src_mem(amo_src_mem),
    .snoop_st_valid(snoop_st_valid), .snoop_st_addr(snoop_st_addr),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .hold(hold), .amo_val_lockup(amo_val_lockup), .amo_result(amo_result),
    .is_fail_sc_mem(is_fail_sc_mem), .resv_valid(resv_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;

  logic [63:0]  mem [logic [63:0]];
  logic [64:0]  exp_res_q [$];  // {fail, result}
  logic [128:0] exp_wr_q [$];   // {word, addr, data}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Lockup monitor: every strobe must match the oldest expected result.
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (rstn && amo_val_lockup) begin
        if (exp_res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL lockup_unexpected: got result 0x%016h with no expectation", amo_result);
        end else begin
          e = exp_res_q.pop_front();
          chk("amo_result", amo_result, e[63:0]);
          chk("is_fail_sc_mem", {63'd0, is_fail_sc_mem}, {63'd0, e[64]});
        end
      end
    end
  end

  // Bus responder: acks after ack_delay cycles, checks request stability and writes.
  initial begin
    int cnt;
    logic pend;
    logic [63:0] p_addr, p_wdata, old, mask;
    logic p_we;
    logic [128:0] w;
    cnt = 0; pend = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (!bus_req) begin
        cnt = 0; pend = 1'b0;
      end else begin
        if (pend) begin
          chk("bus_addr_stable", bus_addr, p_addr);
          chk("bus_we_stable", {63'd0, bus_we}, {63'd0, p_we});
          chk("bus_wdata_stable", bus_wdata, p_wdata);
        end else begin
          pend = 1'b1; p_addr = bus_addr; p_we = bus_we; p_wdata = bus_wdata;
        end
        if (cnt == ack_delay) begin
          bus_ack = 1'b1; cnt = 0; pend = 1'b0;
          old = mem.exists(bus_addr) ? mem[bus_addr] : 64'd0;
          if (!bus_we) begin
            bus_rdata = old;
          end else if (exp_wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_write_unexpected: got addr 0x%016h data 0x%016h", bus_addr, bus_wdata);
          end else begin
            w = exp_wr_q.pop_front();
            mask = w[128] ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
            chk("bus_write_addr", bus_addr, w[127:64]);
            chk("bus_write_data", bus_wdata & mask, w[63:0] & mask);
            mem[bus_addr] = (old & ~mask) | (bus_wdata & mask);
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic do_op(input logic [4:0] f5, input logic w, input logic [63:0] a,
                       input logic [63:0] s, input int exp_hold, input logic [63:0] exp_res,
                       input logic exp_fail, input logic wr_en, input logic [63:0] wd,
                       input logic snp, input logic [63:0] snp_a, input int flush_at);
    int hold_cnt;
    int lock_cyc;
    lock_cyc = 0;
    hold_cnt = 0;
    @(negedge clk);
    is_amo_instr_mem = 1'b1; amo_funct5_mem = f5; amo_word_mem = w;
    amo_addr_mem = a; amo_src_mem = s;
    snoop_st_valid = snp; snoop_st_addr = snp_a;
    exp_res_q.push_back({exp_fail, exp_res});
    if (wr_en) exp_wr_q.push_back({w, a, wd});
    for (int c = 1; c <= 100 && lock_cyc == 0; c++) begin
      #1;
      if (hold) hold_cnt++;
      if (amo_val_lockup) lock_cyc = c;
      @(negedge clk);
      is_amo_instr_mem = 1'b0;
      snoop_st_valid = 1'b0;
      flush_mem = (c == flush_at);
    end
    flush_mem = 1'b0;
    chk("hold_cycles", 64'(hold_cnt), 64'(exp_hold));
    chk("lockup_cycle", 64'(lock_cyc), 64'(exp_hold + 1));
  endtask

  task automatic snoop(input logic [63:0] a);
    @(negedge clk);
    snoop_st_valid = 1'b1; snoop_st_addr = a;
    @(negedge clk);
    snoop_st_valid = 1'b0;
  endtask

  task automatic killed_start(input logic c, input logic f);
    @(negedge clk);
    is_amo_instr_mem = 1'b1; amo_funct5_mem = F_SWAP; amo_word_mem = 1'b0;
    amo_addr_mem = 64'h1000; amo_src_mem = 64'h77;
    cancel_instr_mem = c; flush_mem = f;
    #1 chk("killed_hold", {63'd0, hold}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      is_amo_instr_mem = 1'b0; cancel_instr_mem = 1'b0; flush_mem = 1'b0;
      #1 chk("killed_bus_req", {63'd0, bus_req}, 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"}, {63'd0, bus_req}, 64'd0);
    chk({tag, "_bus_we"}, {63'd0, bus_we}, 64'd0);
    chk({tag, "_bus_addr"}, bus_addr, 64'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 64'd0);
    chk({tag, "_hold"}, {63'd0, hold}, 64'd0);
    chk({tag, "_lockup"}, {63'd0, amo_val_lockup}, 64'd0);
    chk({tag, "_result"}, amo_result, 64'd0);
    chk({tag, "_fail"}, {63'd0, is_fail_sc_mem}, 64'd0);
    chk({tag, "_resv_valid"}, {63'd0, resv_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rstn = 1'b0;
    is_amo_instr_mem = 1'b0; amo_funct5_mem = '0; amo_word_mem = 1'b0;
    cancel_instr_mem = 1'b0; flush_mem = 1'b0;
    amo_addr_mem = '0; amo_src_mem = '0;
    snoop_st_valid = 1'b0; snoop_st_addr = '0;
    mem[64'h1000] = 64'd5;
    mem[64'h2000] = 64'h1234;
    mem[64'h3000] = 64'h0000_0000_FFFF_FFFE;
    mem[64'h3010] = 64'h0000_0000_7FFF_FFFF;
    mem[64'h3018] = 64'hFFFF_FFFF_FFFF_FFF0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;

    // f5, word, addr, src, hold, result, fail, wr_en, wdata, snoop, snoop_addr, flush_at
    do_op(F_ADD,  1'b0, 64'h1000, 64'd7, 3, 64'd5, 1'b0, 1'b1, 64'd12, 1'b0, 64'd0, 0);
    do_op(F_MIN,  1'b1, 64'h3000, 64'd3, 3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 64'd0, 0);
    do_op(F_MINU, 1'b1, 64'h3000, 64'd3, 3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 64'd3, 1'b0, 64'd0, 0);
    do_op(F_ADD,  1'b1, 64'h3010, 64'd1, 3, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b1, 64'h8000_0000, 1'b0, 64'd0, 0);
    do_op(F_SWAP, 1'b0, 64'h1000, 64'h55, 3, 64'd12, 1'b0, 1'b1, 64'h55, 1'b0, 64'd0, 0);
    do_op(F_MAX,  1'b0, 64'h3018, 64'd5, 3, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b1, 64'd5, 1'b0, 64'd0, 0);

    // LR then successful SC
    do_op(F_LR, 1'b0, 64'h2000, 64'd0, 2, 64'h1234, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 0);
    chk("resv_after_lr", {63'd0, resv_valid}, 64'd1);
    do_op(F_SC, 1'b0, 64'h2000, 64'hAB, 2, 64'd0, 1'b0, 1'b1, 64'hAB, 1'b0, 64'd0, 0);
    chk("resv_after_sc", {63'd0, resv_valid}, 64'd0);
    // SC with no reservation
    do_op(F_SC, 1'b0, 64'h2000, 64'h11, 1, 64'd1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 0);

    // Snoop outside the granule keeps it, inside the granule kills it
    do_op(F_LR, 1'b0, 64'h2000, 64'd0, 2, 64'hAB, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 0);
    snoop(64'h2008);
    #1 chk("resv_other_granule", {63'd0, resv_valid}, 64'd1);
    snoop(64'h2004);
    #1 chk("resv_same_granule", {63'd0, resv_valid}, 64'd0);
    do_op(F_SC, 1'b0, 64'h2000, 64'h99, 1, 64'd1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 0);

    // Snoop in the SC start cycle
    do_op(F_LR, 1'b0, 64'h2000, 64'd0, 2, 64'hAB, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 0);
    do_op(F_SC, 1'b0, 64'h2000, 64'h99, 1, 64'd1, 1'b1, 1'b0, 64'd0, 1'b1, 64'h2000, 0);
    chk("resv_after_snoop_sc", {63'd0, resv_valid}, 64'd0);

    killed_start(1'b1, 1'b0);
    killed_start(1'b0, 1'b1);

    // Slow bus with a flush during RD
    ack_delay = 4;
    do_op(F_ADD, 1'b0, 64'h1000, 64'd1, 11, 64'h55, 1'b0, 1'b1, 64'h56, 1'b0, 64'd0, 2);

    // Reset in the middle of a write
    do_op(F_LR, 1'b0, 64'h2000, 64'd0, 6, 64'hAB, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 0);
    @(negedge clk);
    is_amo_instr_mem = 1'b1; amo_funct5_mem = F_ADD; amo_word_mem = 1'b0;
    amo_addr_mem = 64'h1000; amo_src_mem = 64'd1;
    @(negedge clk);
    is_amo_instr_mem = 1'b0;
    guard = 0;
    while (!bus_we && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_wr", {63'd0, bus_we}, 64'd1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_all_zero("midwr_reset");
    @(negedge clk);
    rstn = 1'b1;
    ack_delay = 0;
    repeat (4) @(negedge clk);

    chk("pending_results", 64'(exp_res_q.size()), 64'd0);
    chk("pending_writes", 64'(exp_wr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
